// File: rtl/dcp_pkg.sv
// ----------------------------------------------------------------------------
// dcp_pkg
// Physical address type shared across the cohort tile.
// ----------------------------------------------------------------------------
package dcp_pkg;

    localparam int PADDR_W = 40;

    typedef logic [PADDR_W-1:0] paddr_t;

endpackage : dcp_pkg

// File: rtl/tri_pkg.sv
// ----------------------------------------------------------------------------
// tri_pkg
// TRI port field widths and the L2 arbiter state encoding.
// ----------------------------------------------------------------------------
package tri_pkg;

    localparam int TRI_TYPE_W      = 5;
    localparam int TRI_REQ_DATA_W  = 64;
    localparam int TRI_RESP_DATA_W = 64;
    localparam int TRI_AMO_W       = 4;

    typedef enum logic {
        S_ARB   = 1'b0,
        S_ISSUE = 1'b1
    } arb_state_t;

endpackage : tri_pkg

// File: rtl/tri_owner_fifo.sv
// ----------------------------------------------------------------------------
// tri_owner_fifo
// Small index FIFO recording which master owns each in-flight L2 request.
// Responses return in order, so the head always names the next owner.
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   push, push_data enqueue an owner index
//   pop             dequeue the head
//   head            owner index at the head (valid when !empty)
//   full, empty     occupancy flags from the registered count
//   count           current occupancy, 0..DEPTH
// ----------------------------------------------------------------------------
module tri_owner_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic [W-1:0]            push_data,
    input  logic                    pop,
    output logic [W-1:0]            head,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    // Pointers wrap at DEPTH, which need not fill the pointer width.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign full  = (cnt_q == CNT_W'(DEPTH));
    assign empty = (cnt_q == '0);
    assign count = cnt_q;

    a_no_overflow:  assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) !(pop && empty));

endmodule : tri_owner_fifo

// File: rtl/tri_l2_arbiter.sv
// ----------------------------------------------------------------------------
// tri_l2_arbiter
// Merges NUM_MASTERS TRI master ports onto one TRI port toward L2.
// Requests are granted round-robin and held until L2 accepts them; the owner
// of every accepted request is queued so in-order responses are steered back
// to the issuing master. Invalidations are broadcast unchanged.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   m_req_*               per-master request (flat, NUM_MASTERS slices)
//   m_resp_val/ack        per-master response handshake
//   m_resp_type/data      response payload shared by all masters
//   m_inv_valid/addr      broadcast invalidation
//   l2_req_*              muxed request toward L2
//   l2_resp_*             response from L2
//   l2_inv_*              invalidation from L2
//   err_orphan_resp       sticky: response seen with no owner outstanding
//   perf                  (TRI_ARB_PERF_EN only) performance counter access
//
// Optional build macro: TRI_ARB_PERF_EN adds grant, full-stall and
// request-wait counters behind the perf_if.slave port.
// ----------------------------------------------------------------------------
module tri_l2_arbiter
    import tri_pkg::*;
    import dcp_pkg::*;
#(
    parameter int NUM_MASTERS     = 2,
    parameter int MAX_OUTSTANDING = 2
) (
`ifdef TRI_ARB_PERF_EN
    perf_if.slave                                   perf,
`endif
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic [NUM_MASTERS-1:0]                  m_req_valid,
    output logic [NUM_MASTERS-1:0]                  m_req_ack,
    input  logic [NUM_MASTERS*TRI_TYPE_W-1:0]       m_req_type,
    input  logic [NUM_MASTERS*3-1:0]                m_req_size,
    input  logic [NUM_MASTERS*PADDR_W-1:0]          m_req_addr,
    input  logic [NUM_MASTERS*TRI_REQ_DATA_W-1:0]   m_req_data,
    input  logic [NUM_MASTERS*TRI_AMO_W-1:0]        m_req_amo_op,
    output logic [NUM_MASTERS-1:0]                  m_resp_val,
    input  logic [NUM_MASTERS-1:0]                  m_resp_ack,
    output logic [TRI_TYPE_W-1:0]                   m_resp_type,
    output logic [TRI_RESP_DATA_W-1:0]              m_resp_data,
    output logic [NUM_MASTERS-1:0]                  m_inv_valid,
    output logic [15:0]                             m_inv_addr,
    output logic                                    l2_req_valid,
    input  logic                                    l2_req_ack,
    output logic [TRI_TYPE_W-1:0]                   l2_req_type,
    output logic [2:0]                              l2_req_size,
    output logic [PADDR_W-1:0]                      l2_req_addr,
    output logic [TRI_REQ_DATA_W-1:0]               l2_req_data,
    output logic [TRI_AMO_W-1:0]                    l2_req_amo_op,
    input  logic                                    l2_resp_val,
    output logic                                    l2_resp_ack,
    input  logic [TRI_TYPE_W-1:0]                   l2_resp_type,
    input  logic [TRI_RESP_DATA_W-1:0]              l2_resp_data,
    input  logic                                    l2_inv_valid,
    input  logic [15:0]                             l2_inv_addr,
    output logic                                    err_orphan_resp
);

    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             err_orphan_q, err_orphan_d;

    logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [IDX_W-1:0] fifo_head;
    logic [CNT_W-1:0] fifo_count;

    logic             arb_found;
    logic [IDX_W-1:0] arb_pick;

    tri_owner_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .W     (IDX_W)
    ) u_owner_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (grant_idx_q),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // First requester at or after rr_ptr, wrapping past the last master.
    always_comb begin
        int               j;
        logic [IDX_W-1:0] idx;
        arb_found = 1'b0;
        arb_pick  = '0;
        j         = 0;
        idx       = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            j = int'(rr_ptr_q) + i;
            if (j >= NUM_MASTERS) j = j - NUM_MASTERS;
            idx = IDX_W'(j);
            if (!arb_found && m_req_valid[idx]) begin
                arb_found = 1'b1;
                arb_pick  = idx;
            end
        end
    end

    // Grant FSM; full comes from the registered count, so a same-cycle pop
    // never opens room for a grant.
    always_comb begin
        state_d     = state_q;
        grant_idx_d = grant_idx_q;
        rr_ptr_d    = rr_ptr_q;
        fifo_push   = 1'b0;
        m_req_ack   = '0;
        case (state_q)
            S_ARB: begin
                if (!fifo_full && arb_found) begin
                    grant_idx_d = arb_pick;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (l2_req_ack) begin
                    m_req_ack[grant_idx_q] = 1'b1;
                    fifo_push              = 1'b1;
                    rr_ptr_d = (grant_idx_q == IDX_W'(NUM_MASTERS - 1)) ? '0
                                                                        : grant_idx_q + 1'b1;
                    state_d  = S_ARB;
                end
            end
            default: state_d = S_ARB;
        endcase
    end

    // Response steering; with nobody outstanding the response is swallowed.
    always_comb begin
        m_resp_val   = '0;
        l2_resp_ack  = 1'b0;
        fifo_pop     = 1'b0;
        err_orphan_d = err_orphan_q;
        if (fifo_empty) begin
            l2_resp_ack = l2_resp_val;
            if (l2_resp_val) err_orphan_d = 1'b1;
        end else begin
            m_resp_val[fifo_head] = l2_resp_val;
            l2_resp_ack           = m_resp_ack[fifo_head];
            fifo_pop              = l2_resp_val && m_resp_ack[fifo_head];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_ARB;
            grant_idx_q  <= '0;
            rr_ptr_q     <= '0;
            err_orphan_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_idx_q  <= grant_idx_d;
            rr_ptr_q     <= rr_ptr_d;
            err_orphan_q <= err_orphan_d;
        end
    end

    assign l2_req_valid    = (state_q == S_ISSUE);
    assign l2_req_type     = m_req_type  [grant_idx_q*TRI_TYPE_W     +: TRI_TYPE_W];
    assign l2_req_size     = m_req_size  [grant_idx_q*3              +: 3];
    assign l2_req_addr     = m_req_addr  [grant_idx_q*PADDR_W        +: PADDR_W];
    assign l2_req_data     = m_req_data  [grant_idx_q*TRI_REQ_DATA_W +: TRI_REQ_DATA_W];
    assign l2_req_amo_op   = m_req_amo_op[grant_idx_q*TRI_AMO_W      +: TRI_AMO_W];

    assign m_resp_type     = l2_resp_type;
    assign m_resp_data     = l2_resp_data;
    assign m_inv_valid     = {NUM_MASTERS{l2_inv_valid}};
    assign m_inv_addr      = l2_inv_addr;
    assign err_orphan_resp = err_orphan_q;

    // A granted master must keep its request up until L2 takes it.
    a_req_held:  assert property (@(posedge clk) disable iff (!rst_n)
                                  (state_q == S_ISSUE) |-> m_req_valid[grant_idx_q]);
    a_count_rng: assert property (@(posedge clk) disable iff (!rst_n)
                                  fifo_count <= CNT_W'(MAX_OUTSTANDING));

`ifdef TRI_ARB_PERF_EN
    logic full_stall_ev;
    logic req_wait_ev;

    assign full_stall_ev = (|m_req_valid) && fifo_full;
    assign req_wait_ev   = (state_q == S_ISSUE) && !l2_req_ack;

    for (genvar m = 0; m < NUM_MASTERS; m++) begin : g_grant_cnt
        generic_perf_counter #(.WIDTH(64)) u_grant_cnt (
            .clk            (clk),
            .rst_n          (rst_n),
            .inc            (m_req_ack[m]),
            .toggle_trigger (perf.toggle_trigger),
            .clear_trigger  (perf.clear_trigger),
            .count          (perf.grant_cnt[m])
        );
    end

    generic_perf_counter #(.WIDTH(64)) u_full_stall_cnt (
        .clk            (clk),
        .rst_n          (rst_n),
        .inc            (full_stall_ev),
        .toggle_trigger (perf.toggle_trigger),
        .clear_trigger  (perf.clear_trigger),
        .count          (perf.full_stall_cnt)
    );

    generic_perf_counter #(.WIDTH(64)) u_req_wait_cnt (
        .clk            (clk),
        .rst_n          (rst_n),
        .inc            (req_wait_ev),
        .toggle_trigger (perf.toggle_trigger),
        .clear_trigger  (perf.clear_trigger),
        .count          (perf.req_wait_cnt)
    );
`endif

endmodule : tri_l2_arbiter

// File: tb/tb_tri_l2_arbiter.sv
module tb_tri_l2_arbiter;
    import tri_pkg::*;
    import dcp_pkg::*;

    localparam int N  = 2;
    localparam int MO = 2;

    logic                          clk = 1'b0;
    logic                          rst_n;
    logic [N-1:0]                  m_req_valid, m_req_ack, m_resp_val, m_resp_ack, m_inv_valid;
    logic [N*TRI_TYPE_W-1:0]       m_req_type;
    logic [N*3-1:0]                m_req_size;
    logic [N*PADDR_W-1:0]          m_req_addr;
    logic [N*TRI_REQ_DATA_W-1:0]   m_req_data;
    logic [N*TRI_AMO_W-1:0]        m_req_amo_op;
    logic [TRI_TYPE_W-1:0]         m_resp_type, l2_req_type, l2_resp_type;
    logic [TRI_RESP_DATA_W-1:0]    m_resp_data, l2_resp_data;
    logic [15:0]                   m_inv_addr, l2_inv_addr;
    logic                          l2_req_valid, l2_req_ack, l2_resp_val, l2_resp_ack;
    logic                          l2_inv_valid, err_orphan_resp;
    logic [2:0]                    l2_req_size;
    logic [PADDR_W-1:0]            l2_req_addr;
    logic [TRI_REQ_DATA_W-1:0]     l2_req_data;
    logic [TRI_AMO_W-1:0]          l2_req_amo_op;

    tri_l2_arbiter #(.NUM_MASTERS(N), .MAX_OUTSTANDING(MO)) dut (
        .clk(clk), .rst_n(rst_n),
        .m_req_valid(m_req_valid), .m_req_ack(m_req_ack), .m_req_type(m_req_type),
        .m_req_size(m_req_size), .m_req_addr(m_req_addr), .m_req_data(m_req_data),
        .m_req_amo_op(m_req_amo_op), .m_resp_val(m_resp_val), .m_resp_ack(m_resp_ack),
        .m_resp_type(m_resp_type), .m_resp_data(m_resp_data), .m_inv_valid(m_inv_valid),
        .m_inv_addr(m_inv_addr), .l2_req_valid(l2_req_valid), .l2_req_ack(l2_req_ack),
        .l2_req_type(l2_req_type), .l2_req_size(l2_req_size), .l2_req_addr(l2_req_addr),
        .l2_req_data(l2_req_data), .l2_req_amo_op(l2_req_amo_op), .l2_resp_val(l2_resp_val),
        .l2_resp_ack(l2_resp_ack), .l2_resp_type(l2_resp_type), .l2_resp_data(l2_resp_data),
        .l2_inv_valid(l2_inv_valid), .l2_inv_addr(l2_inv_addr), .err_orphan_resp(err_orphan_resp)
    );

    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;
    int ack0_cnt = 0;

    always @(negedge clk) if (m_req_ack[0] === 1'b1) ack0_cnt++;

    // Per-master request fields held by the bench.
    logic [TRI_TYPE_W-1:0]     b_type [N];
    logic [2:0]                b_size [N];
    logic [PADDR_W-1:0]        b_addr [N];
    logic [TRI_REQ_DATA_W-1:0] b_data [N];
    logic [TRI_AMO_W-1:0]      b_amo  [N];
    logic [N-1:0]              pend;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk); #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic drive_reqs();
        m_req_valid = pend;
        for (int m = 0; m < N; m++) begin
            m_req_type  [m*TRI_TYPE_W     +: TRI_TYPE_W]     = b_type[m];
            m_req_size  [m*3              +: 3]              = b_size[m];
            m_req_addr  [m*PADDR_W        +: PADDR_W]        = b_addr[m];
            m_req_data  [m*TRI_REQ_DATA_W +: TRI_REQ_DATA_W] = b_data[m];
            m_req_amo_op[m*TRI_AMO_W      +: TRI_AMO_W]      = b_amo[m];
        end
    endtask

    task automatic set_req(input int m, input logic [PADDR_W-1:0] a, input logic [TRI_TYPE_W-1:0] t);
        pend[m]   = 1'b1;
        b_addr[m] = a;
        b_type[m] = t;
        b_size[m] = 3'd3;
        b_data[m] = {32'hC0DE_0000, 32'(m)};
        b_amo[m]  = TRI_AMO_W'(m);
        drive_reqs();
    endtask

    task automatic idle_all();
        pend = '0;
        for (int m = 0; m < N; m++) begin
            b_type[m] = '0; b_size[m] = '0; b_addr[m] = '0; b_data[m] = '0; b_amo[m] = '0;
        end
        drive_reqs();
        m_resp_ack = '0; l2_req_ack = 0; l2_resp_val = 0; l2_resp_type = '0;
        l2_resp_data = '0; l2_inv_valid = 0; l2_inv_addr = '0;
    endtask

    // Reference model state for the random phase.
    int  owners[$];
    int  rr, g;
    bit  busy;

    initial begin
        logic [N-1:0] grants[$];
        int a0;
        rst_n = 1'b0;
        idle_all();

        // ---- reset ----
        repeat (3) @(posedge clk);
        smp();
        chk("rst_l2_req_valid", l2_req_valid, 0);
        chk("rst_m_req_ack", m_req_ack, 0);
        chk("rst_m_resp_val", m_resp_val, 0);
        chk("rst_l2_resp_ack", l2_resp_ack, 0);
        chk("rst_err", err_orphan_resp, 0);
        nxt(); rst_n = 1'b1;

        // ---- single master, delayed ack ----
        a0 = ack0_cnt;
        set_req(0, 40'h1000, 5'd1);
        smp(); chk("sm_lat0", l2_req_valid, 0);
        nxt(); smp();
        chk("sm_issue", l2_req_valid, 1);
        chk("sm_addr", l2_req_addr, 40'h1000);
        chk("sm_type", l2_req_type, 1);
        chk("sm_noack", m_req_ack, 0);
        nxt(); smp(); nxt(); smp(); nxt();
        l2_req_ack = 1;
        smp(); chk("sm_ack", m_req_ack, 2'b01);
        nxt(); pend = '0; drive_reqs(); l2_req_ack = 0;
        smp(); chk("sm_idle", l2_req_valid, 0);
        nxt(); smp(); nxt();
        l2_resp_val = 1; l2_resp_data = 64'hDEAD_BEEF; l2_resp_type = 5'd2; m_resp_ack = 2'b11;
        smp();
        chk("sm_resp_val", m_resp_val, 2'b01);
        chk("sm_resp_data", m_resp_data, 64'hDEAD_BEEF);
        chk("sm_resp_ack", l2_resp_ack, 1);
        chk("sm_ack_once", ack0_cnt - a0, 1);
        nxt(); l2_resp_val = 0; m_resp_ack = '0;

        // ---- contention until the owner FIFO fills (rr now points at M1) ----
        set_req(0, 40'h2000, 5'd1);
        set_req(1, 40'h3000, 5'd1);
        l2_req_ack = 1;
        for (int c = 0; c < 6; c++) begin
            smp();
            if (m_req_ack != '0) grants.push_back(m_req_ack);
            nxt();
        end
        l2_req_ack = 0;
        chk("ct_ngrants", grants.size(), 2);
        if (grants.size() == 2) begin
            chk("ct_grant0", grants[0], 2'b10);
            chk("ct_grant1", grants[1], 2'b01);
        end
        for (int c = 0; c < 2; c++) begin
            smp(); chk("full_no_grant", l2_req_valid, 0); nxt();
        end

        // ---- back-pressure on the head owner (M1) ----
        l2_resp_val = 1; l2_resp_data = 64'h1111; m_resp_ack = 2'b01;
        for (int c = 0; c < 5; c++) begin
            smp();
            chk("bp_resp_val", m_resp_val, 2'b10);
            chk("bp_l2_ack", l2_resp_ack, 0);
            chk("bp_still_full", l2_req_valid, 0);
            nxt();
        end
        m_resp_ack = 2'b11;
        smp();
        chk("bp_release_ack", l2_resp_ack, 1);
        chk("bp_release_data", m_resp_data, 64'h1111);
        nxt(); l2_resp_val = 0; m_resp_ack = '0;
        smp(); chk("pop_no_same_grant", l2_req_valid, 0);
        nxt(); smp();
        chk("regrant_valid", l2_req_valid, 1);
        chk("regrant_m1", l2_req_addr, 40'h3000);

        // ---- invalidation while a request waits in issue ----
        nxt(); l2_inv_valid = 1; l2_inv_addr = 16'h0042;
        smp();
        chk("inv_valid", m_inv_valid, 2'b11);
        chk("inv_addr", m_inv_addr, 16'h0042);
        chk("inv_req_kept", l2_req_valid, 1);
        chk("inv_addr_kept", l2_req_addr, 40'h3000);
        nxt(); l2_inv_valid = 0; l2_req_ack = 1;
        smp(); chk("inv_then_ack", m_req_ack, 2'b10);
        nxt(); l2_req_ack = 0; pend = '0; drive_reqs();

        // drain M0 then M1
        l2_resp_val = 1; m_resp_ack = 2'b11; l2_resp_data = 64'hA;
        smp(); chk("drain0", m_resp_val, 2'b01);
        nxt(); l2_resp_data = 64'hB;
        smp(); chk("drain1", m_resp_val, 2'b10);
        nxt(); l2_resp_val = 0; m_resp_ack = '0;

        // ---- orphan response, then reset in the middle of issue ----
        l2_resp_val = 1;
        smp();
        chk("orph_ack", l2_resp_ack, 1);
        chk("orph_no_route", m_resp_val, 0);
        chk("orph_err_pre", err_orphan_resp, 0);
        nxt(); l2_resp_val = 0;
        smp(); chk("orph_err", err_orphan_resp, 1);
        set_req(0, 40'h5000, 5'd1);
        nxt(); smp();
        chk("orph_err_sticky", err_orphan_resp, 1);
        chk("pre_rst_issue", l2_req_valid, 1);
        rst_n = 1'b0;
        nxt(); pend = '0; drive_reqs();
        smp();
        chk("rst_mid_valid", l2_req_valid, 0);
        chk("rst_mid_err", err_orphan_resp, 0);
        chk("rst_mid_ack", m_req_ack, 0);
        chk("rst_mid_resp", m_resp_val, 0);
        chk("rst_mid_l2ack", l2_resp_ack, 0);
        nxt(); rst_n = 1'b1; idle_all();

        // ---- randomized traffic against the reference model ----
        rr = 0; busy = 0; g = 0; owners.delete();
        for (int c = 0; c < 400; c++) begin
            logic [N-1:0] exp_ack, exp_rv;
            logic         exp_l2ack, full, pop, pushv;
            int           pushg;
            for (int m = 0; m < N; m++) begin
                if (!pend[m] && $urandom_range(0, 2) == 0) begin
                    pend[m]   = 1'b1;
                    b_type[m] = TRI_TYPE_W'($urandom);
                    b_size[m] = 3'($urandom);
                    b_addr[m] = PADDR_W'({$urandom, $urandom});
                    b_data[m] = {$urandom, $urandom};
                    b_amo[m]  = TRI_AMO_W'($urandom);
                end
            end
            drive_reqs();
            l2_req_ack   = 1'($urandom_range(0, 1));
            l2_resp_val  = (owners.size() > 0) && ($urandom_range(0, 2) != 0);
            l2_resp_data = {$urandom, $urandom};
            l2_resp_type = TRI_TYPE_W'($urandom);
            m_resp_ack   = N'($urandom);
            l2_inv_valid = 1'($urandom_range(0, 1));
            l2_inv_addr  = 16'($urandom);

            smp();
            exp_ack = '0;
            if (busy && l2_req_ack) exp_ack[g] = 1'b1;
            exp_rv = '0;
            exp_l2ack = 1'b0;
            if (owners.size() > 0) begin
                if (l2_resp_val) exp_rv[owners[0]] = 1'b1;
                exp_l2ack = m_resp_ack[owners[0]];
            end
            chk("rnd_req_valid", l2_req_valid, busy);
            if (busy) chk("rnd_req_fields", {l2_req_type, l2_req_size, l2_req_addr, l2_req_data, l2_req_amo_op},
                          {b_type[g], b_size[g], b_addr[g], b_data[g], b_amo[g]});
            chk("rnd_req_ack", m_req_ack, exp_ack);
            chk("rnd_resp_val", m_resp_val, exp_rv);
            chk("rnd_l2_resp_ack", l2_resp_ack, exp_l2ack);
            chk("rnd_resp_payload", {m_resp_type, m_resp_data}, {l2_resp_type, l2_resp_data});
            chk("rnd_inv", {m_inv_valid, m_inv_addr}, {{N{l2_inv_valid}}, l2_inv_addr});
            chk("rnd_err", err_orphan_resp, 0);

            // advance the model by one clock
            full  = (owners.size() == MO);
            pop   = (owners.size() > 0) && l2_resp_val && m_resp_ack[owners[0]];
            pushv = 1'b0;
            pushg = 0;
            if (busy) begin
                if (l2_req_ack) begin
                    pushv   = 1'b1;
                    pushg   = g;
                    rr      = (g + 1) % N;
                    busy    = 0;
                    pend[g] = 1'b0;
                end
            end else if (!full) begin
                for (int k = 0; k < N; k++) begin
                    if (!busy && pend[(rr + k) % N]) begin
                        busy = 1;
                        g    = (rr + k) % N;
                    end
                end
            end
            if (pop) void'(owners.pop_front());
            if (pushv) owners.push_back(pushg);
            nxt();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule : tb_tri_l2_arbiter
